register_file: RTL and testbench
================================

Name: register_file

Overview:
- Architectural register file with rename tags for the out-of-order RISC-V core.
- Sits opposite the reorder buffer on three paths: the launch (rename) path, the commit (writeback) path, and the operand-query path.
- Holds 32 committed 32-bit values and, for each register, the ROB id of its youngest in-flight producer (0 = none).
- Answers the two decode-time operand queries combinationally.

Parameters:
- XLEN, 32, data width of each register and of the commit value.
- ROB_ID_W, 5, width of ROB ids. Id 0 means "no producer"; valid ids are 1..31.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- rdy_in  input  1  ready; when low, all state holds
- _clear  input  1  misprediction flush from the ROB
- _rf_launch_ready  input  1  rename request this cycle
- _rf_launch_rob_id  input  5  ROB id of the launching instruction
- _rf_launch_register_id  input  5  destination register of the launching instruction
- _rf_commit_ready  input  1  commit write this cycle
- _rf_commit_rob_id  input  5  ROB id being committed
- _rf_commit_register_id  input  5  destination register being committed
- _rf_commit_value  input  XLEN  committed value
- _ask_rd_1  input  5  source register query 1
- _ask_rd_2  input  5  source register query 2
- _dep_rd_1  output  5  pending producer ROB id for query 1 (0 = value is final)
- _dep_rd_2  output  5  pending producer ROB id for query 2
- _dep_value_1  output  XLEN  committed value for query 1
- _dep_value_2  output  XLEN  committed value for query 2

Behaviour:
- State: val[0..31] (XLEN bits each) and dep[0..31] (5 bits each).
- Reset (rst_in high, asynchronous): all val and all dep are cleared to 0 immediately. Outputs are combinational from state, so after reset every query returns dep 0, value 0.
- All updates below happen on the posedge clk_in, and only when rdy_in is 1. When rdy_in is 0, no state changes; query outputs still track the current state.
- Commit:
  - If _rf_commit_ready and the commit register != 0, then val[commit register] <= _rf_commit_value.
  - If, in addition, dep[commit register] == _rf_commit_rob_id, then dep[commit register] <= 0. Otherwise dep is untouched, because a younger producer owns the register.
- Launch:
  - If _rf_launch_ready, _clear is 0, and the launch register != 0, then dep[launch register] <= _rf_launch_rob_id.
- Launch and commit on the same register in the same cycle: launch wins the dep field (dep becomes the launch id); the commit still writes val.
- Clear (_clear = 1 with rdy_in = 1):
  - Every dep[i] <= 0.
  - Launch is ignored.
  - A commit presented in the same cycle still writes val. Clear never restores val.
- Register x0: val[0] and dep[0] are permanently 0. Writes and launches targeting x0 are dropped.
- Query path, per port k, combinational, zero latency:
  - Default: _dep_rd_k = dep[_ask_rd_k] and _dep_value_k = val[_ask_rd_k].
  - Commit bypass: if _rf_commit_ready, the commit register == _ask_rd_k != 0, and dep[_ask_rd_k] == _rf_commit_rob_id, then _dep_rd_k = 0 and _dep_value_k = _rf_commit_value.
  - No launch bypass: a launch in the current cycle is not visible to queries until the next cycle. This is required so an instruction never depends on itself (e.g. add x5,x5,x1).
  - _ask_rd_k == 0 always returns dep 0, value 0.
- Both query ports are independent and may address the same register.

Test Plan:
- Reset behaviour: assert rst_in mid-run between clock edges -> all queries immediately return dep 0, value 0; e.g. _ask_rd_1=7 gives _dep_rd_1=0, _dep_value_1=0.
- Launch then commit:
  - Launch rob 3 -> x5, then next cycle query x5 -> _dep_rd_1=3.
  - Commit rob 3, x5, 0x1234 with a same-cycle query of x5 -> bypass gives dep 0, value 0x1234.
  - Next cycle -> dep 0, value 0x1234 from state.
- Stale commit: launch rob 3 -> x5, then rob 6 -> x5; commit rob 3, x5, 0xAA -> val[x5]=0xAA, dep[x5] stays 6; query returns dep 6.
- Simultaneous launch and commit on x8: dep[x8]=2; in one cycle commit rob 2 (value 0x55) and launch rob 9 -> dep[x8]=9, val[x8]=0x55.
- Clear: deps on x1=4, x2=5; assert _clear together with a launch rob 7 -> x3 -> all deps 0, x3 dep stays 0, values unchanged.
- x0 and rdy_in:
  - Launch or commit to x0 with value 0xFFFF -> query x0 returns 0/0.
  - With rdy_in=0, launch rob 4 -> x9 -> dep[x9] remains 0.

Source files
------------

// File: rtl/register_file.sv
// Architectural register file with rename tags. It stores committed values and
// the ROB id of each register's youngest in-flight producer, and answers two operand queries.
module register_file #(
    parameter int XLEN     = 32,
    parameter int ROB_ID_W = 5
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                _clear,
    input  logic                _rf_launch_ready,
    input  logic [ROB_ID_W-1:0] _rf_launch_rob_id,
    input  logic [4:0]          _rf_launch_register_id,
    input  logic                _rf_commit_ready,
    input  logic [ROB_ID_W-1:0] _rf_commit_rob_id,
    input  logic [4:0]          _rf_commit_register_id,
    input  logic [XLEN-1:0]     _rf_commit_value,
    input  logic [4:0]          _ask_rd_1,
    input  logic [4:0]          _ask_rd_2,
    output logic [ROB_ID_W-1:0] _dep_rd_1,
    output logic [ROB_ID_W-1:0] _dep_rd_2,
    output logic [XLEN-1:0]     _dep_value_1,
    output logic [XLEN-1:0]     _dep_value_2
);

    localparam int NUM_REGS = 32;

    logic [XLEN-1:0]     val [NUM_REGS];
    logic [ROB_ID_W-1:0] dep [NUM_REGS];

    logic commit_live;
    logic launch_live;
    logic commit_owns;

    assign commit_live = _rf_commit_ready && (_rf_commit_register_id != 5'd0);
    assign launch_live = _rf_launch_ready && !_clear && (_rf_launch_register_id != 5'd0);
    assign commit_owns = (dep[_rf_commit_register_id] == _rf_commit_rob_id);

    // Entry 0 is never written, so x0 stays zero without extra gating.
    // Later assignments win: clear beats the commit tag release, and launch beats commit.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                val[i] <= '0;
                dep[i] <= '0;
            end
        end else if (rdy_in) begin
            if (commit_live) begin
                val[_rf_commit_register_id] <= _rf_commit_value;
                if (commit_owns) begin
                    dep[_rf_commit_register_id] <= '0;
                end
            end
            if (_clear) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    dep[i] <= '0;
                end
            end else if (launch_live) begin
                dep[_rf_launch_register_id] <= _rf_launch_rob_id;
            end
        end
    end

    // Queries see committing values immediately, but never a same-cycle launch,
    // so an instruction cannot end up waiting on itself.
    always_comb begin
        _dep_rd_1    = dep[_ask_rd_1];
        _dep_value_1 = val[_ask_rd_1];
        if (commit_live && (_rf_commit_register_id == _ask_rd_1) &&
            (dep[_ask_rd_1] == _rf_commit_rob_id)) begin
            _dep_rd_1    = '0;
            _dep_value_1 = _rf_commit_value;
        end
        if (_ask_rd_1 == 5'd0) begin
            _dep_rd_1    = '0;
            _dep_value_1 = '0;
        end
    end

    always_comb begin
        _dep_rd_2    = dep[_ask_rd_2];
        _dep_value_2 = val[_ask_rd_2];
        if (commit_live && (_rf_commit_register_id == _ask_rd_2) &&
            (dep[_ask_rd_2] == _rf_commit_rob_id)) begin
            _dep_rd_2    = '0;
            _dep_value_2 = _rf_commit_value;
        end
        if (_ask_rd_2 == 5'd0) begin
            _dep_rd_2    = '0;
            _dep_value_2 = '0;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a table of per-cycle vectors with hand-computed
// query results, followed by an asynchronous reset sequence.
module tb_register_file;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic        _rf_launch_ready;
    logic [4:0]  _rf_launch_rob_id;
    logic [4:0]  _rf_launch_register_id;
    logic        _rf_commit_ready;
    logic [4:0]  _rf_commit_rob_id;
    logic [4:0]  _rf_commit_register_id;
    logic [31:0] _rf_commit_value;
    logic [4:0]  _ask_rd_1;
    logic [4:0]  _ask_rd_2;
    logic [4:0]  _dep_rd_1;
    logic [4:0]  _dep_rd_2;
    logic [31:0] _dep_value_1;
    logic [31:0] _dep_value_2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rdy;
        logic        clr;
        logic        lr;
        logic [4:0]  lrob;
        logic [4:0]  lreg;
        logic        cr;
        logic [4:0]  crob;
        logic [4:0]  creg;
        logic [31:0] cval;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  ed1;
        logic [31:0] ev1;
        logic [4:0]  ed2;
        logic [31:0] ev2;
    } vec_t;

    vec_t vecs[$];

    register_file dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .rdy_in                 (rdy_in),
        ._clear                 (_clear),
        ._rf_launch_ready       (_rf_launch_ready),
        ._rf_launch_rob_id      (_rf_launch_rob_id),
        ._rf_launch_register_id (_rf_launch_register_id),
        ._rf_commit_ready       (_rf_commit_ready),
        ._rf_commit_rob_id      (_rf_commit_rob_id),
        ._rf_commit_register_id (_rf_commit_register_id),
        ._rf_commit_value       (_rf_commit_value),
        ._ask_rd_1              (_ask_rd_1),
        ._ask_rd_2              (_ask_rd_2),
        ._dep_rd_1              (_dep_rd_1),
        ._dep_rd_2              (_dep_rd_2),
        ._dep_value_1           (_dep_value_1),
        ._dep_value_2           (_dep_value_2)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic vec_t mk(int rdy, int clr, int lr, int lrob, int lreg,
                                int cr, int crob, int creg, int cval,
                                int a1, int a2, int ed1, int ev1, int ed2, int ev2);
        vec_t v;
        v.rdy  = rdy[0];
        v.clr  = clr[0];
        v.lr   = lr[0];
        v.lrob = lrob[4:0];
        v.lreg = lreg[4:0];
        v.cr   = cr[0];
        v.crob = crob[4:0];
        v.creg = creg[4:0];
        v.cval = cval;
        v.a1   = a1[4:0];
        v.a2   = a2[4:0];
        v.ed1  = ed1[4:0];
        v.ev1  = ev1;
        v.ed2  = ed2[4:0];
        v.ev2  = ev2;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s vec%0d got=%0h want=%0h", name, idx, got, want);
        end
    endtask

    // Inputs change at the falling edge; outputs are checked 1ns later, before the
    // rising edge that applies the update.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk_in);
        rdy_in                 = v.rdy;
        _clear                 = v.clr;
        _rf_launch_ready       = v.lr;
        _rf_launch_rob_id      = v.lrob;
        _rf_launch_register_id = v.lreg;
        _rf_commit_ready       = v.cr;
        _rf_commit_rob_id      = v.crob;
        _rf_commit_register_id = v.creg;
        _rf_commit_value       = v.cval;
        _ask_rd_1              = v.a1;
        _ask_rd_2              = v.a2;
        #1;
    endtask

    initial begin
        rst_in = 1'b1;
        applyStimulus(mk(1,0, 0,0,0, 0,0,0,0, 0,0, 0,0,0,0));
        @(negedge clk_in);
        rst_in = 1'b0;

        //           rdy clr lr lrob lreg cr crob creg cval     a1 a2 ed1 ev1      ed2 ev2
        vecs.push_back(mk(1,0, 0,0,0,  0,0,0,0,            7, 0,  0,0,           0,0));
        vecs.push_back(mk(1,0, 1,3,5,  0,0,0,0,            5, 5,  0,0,           0,0));
        vecs.push_back(mk(1,0, 0,0,0,  0,0,0,0,            5, 0,  3,0,           0,0));
        vecs.push_back(mk(1,0, 0,0,0,  1,3,5,32'h1234,     5, 5,  0,32'h1234,    0,32'h1234));
        vecs.push_back(mk(1,0, 0,0,0,  0,0,0,0,            5, 0,  0,32'h1234,    0,0));
        vecs.push_back(mk(1,0, 1,3,5,  0,0,0,0,            5, 5,  0,32'h1234,    0,32'h1234));
        vecs.push_back(mk(1,0, 1,6,5,  0,0,0,0,            5, 5,  3,32'h1234,    3,32'h1234));
        vecs.push_back(mk(1,0, 0,0,0,  1,3,5,32'hAA,       5, 5,  6,32'h1234,    6,32'h1234));
        vecs.push_back(mk(1,0, 0,0,0,  0,0,0,0,            5, 5,  6,32'hAA,      6,32'hAA));
        vecs.push_back(mk(1,0, 1,2,8,  0,0,0,0,            8, 8,  0,0,           0,0));
        vecs.push_back(mk(1,0, 1,9,8,  1,2,8,32'h55,       8, 8,  0,32'h55,      0,32'h55));
        vecs.push_back(mk(1,0, 0,0,0,  0,0,0,0,            8, 5,  9,32'h55,      6,32'hAA));
        vecs.push_back(mk(1,0, 1,4,1,  0,0,0,0,            1, 1,  0,0,           0,0));
        vecs.push_back(mk(1,0, 1,5,2,  0,0,0,0,            1, 2,  4,0,           0,0));
        vecs.push_back(mk(1,1, 1,7,3,  0,0,0,0,            1, 2,  4,0,           5,0));
        vecs.push_back(mk(1,0, 0,0,0,  0,0,0,0,            3, 1,  0,0,           0,0));
        vecs.push_back(mk(1,0, 0,0,0,  0,0,0,0,            2, 5,  0,0,           0,32'hAA));
        vecs.push_back(mk(1,0, 0,0,0,  0,0,0,0,            8, 2,  0,32'h55,      0,0));
        vecs.push_back(mk(1,0, 1,1,0,  1,0,0,32'hFFFF,     0, 0,  0,0,           0,0));
        vecs.push_back(mk(1,0, 0,0,0,  0,0,0,0,            0, 0,  0,0,           0,0));
        vecs.push_back(mk(1,0, 1,10,6, 0,0,0,0,            6, 6,  0,0,           0,0));
        vecs.push_back(mk(1,1, 0,0,0,  1,10,6,32'h77,      6, 6,  0,32'h77,      0,32'h77));
        vecs.push_back(mk(1,0, 0,0,0,  0,0,0,0,            6, 6,  0,32'h77,      0,32'h77));
        vecs.push_back(mk(0,0, 1,4,9,  0,0,0,0,            9, 9,  0,0,           0,0));
        vecs.push_back(mk(1,0, 0,0,0,  0,0,0,0,            9, 9,  0,0,           0,0));
        vecs.push_back(mk(0,0, 0,0,0,  1,6,5,32'h99,       5, 5,  0,32'hAA,      0,32'hAA));
        vecs.push_back(mk(1,0, 0,0,0,  0,0,0,0,            5, 6,  0,32'hAA,      0,32'h77));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput("dep1", i, 32'(_dep_rd_1),   32'(vecs[i].ed1));
            checkOutput("val1", i, _dep_value_1,     vecs[i].ev1);
            checkOutput("dep2", i, 32'(_dep_rd_2),   32'(vecs[i].ed2));
            checkOutput("val2", i, _dep_value_2,     vecs[i].ev2);
        end

        // Reset asserted between edges must clear state without waiting for a clock.
        applyStimulus(mk(1,0, 1,12,8, 0,0,0,0, 8, 5, 9,32'h55, 0,32'hAA));
        applyStimulus(mk(1,0, 0,0,0,  0,0,0,0, 8, 5, 12,32'h55, 0,32'hAA));
        checkOutput("pre_rst_dep1", 100, 32'(_dep_rd_1), 32'd12);
        checkOutput("pre_rst_val2", 100, _dep_value_2,    32'hAA);
        rst_in = 1'b1;
        #1;
        checkOutput("rst_dep1", 101, 32'(_dep_rd_1), 32'd0);
        checkOutput("rst_val1", 101, _dep_value_1,    32'd0);
        checkOutput("rst_val2", 101, _dep_value_2,    32'd0);
        _ask_rd_1 = 5'd7;
        _ask_rd_2 = 5'd6;
        #1;
        checkOutput("rst_x7", 102, _dep_value_1, 32'd0);
        checkOutput("rst_x6", 102, _dep_value_2, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        applyStimulus(mk(1,0, 0,0,0, 0,0,0,0, 8, 5, 0,0, 0,0));
        checkOutput("post_rst_dep1", 103, 32'(_dep_rd_1), 32'd0);
        checkOutput("post_rst_val2", 103, _dep_value_2,    32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
